// File: rtl/pwm_pkg.sv
// Shared PWM constants and decoder state encoding, common to the decoder and the generator.
package pwm_pkg;

    localparam int unsigned PwmDcWidthDef = 8;
    localparam int unsigned CntWidthDef   = 16;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StHigh  = 2'd1,
        StLow   = 2'd2,
        StStuck = 2'd3
    } pwm_state_e;

endpackage

// File: rtl/pwm_div.sv
// Restoring divider: quo_o = floor(num_i * 2^W / den_i), one quotient bit per cycle.
// Requires num_i < den_i so the quotient fits W bits.
module pwm_div #(
    parameter int unsigned W         = 8,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [CNT_WIDTH-1:0] num_i,
    input  logic [CNT_WIDTH-1:0] den_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [W-1:0]         quo_o
);

    localparam int unsigned CW = $clog2(W + 1);

    logic                 busy_q;
    logic [CW-1:0]        cnt_q;
    logic [CNT_WIDTH-1:0] rem_q;
    logic [CNT_WIDTH-1:0] den_q;
    logic [W-1:0]         quo_q;

    logic [CNT_WIDTH:0]   rem_sh;
    logic [CNT_WIDTH:0]   rem_nx;
    logic                 ge;
    logic [W-1:0]         quo_nx;

    // The low W numerator bits are zero, so each step shifts in a 0.
    always_comb begin
        rem_sh = {rem_q, 1'b0};
        ge     = (rem_sh >= {1'b0, den_q});
        rem_nx = ge ? (rem_sh - {1'b0, den_q}) : rem_sh;
        quo_nx = {quo_q[W-2:0], ge};
    end

    assign busy_o = busy_q;
    assign done_o = busy_q && (cnt_q == CW'(1));
    assign quo_o  = quo_nx;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            den_q  <= '0;
            quo_q  <= '0;
        end else if (start_i && !busy_q) begin
            busy_q <= 1'b1;
            cnt_q  <= CW'(W);
            rem_q  <= num_i;
            den_q  <= den_i;
            quo_q  <= '0;
        end else if (busy_q) begin
            rem_q <= rem_nx[CNT_WIDTH-1:0];
            quo_q <= quo_nx;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pwm_decoder.sv
// Measures period and duty cycle of an asynchronous PWM input; flags a stuck level on timeout.
module pwm_decoder
    import pwm_pkg::*;
#(
    parameter int unsigned PWM_DC_WIDTH   = PwmDcWidthDef,
    parameter int unsigned CNT_WIDTH      = CntWidthDef,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    IN_PWM,
    output logic [PWM_DC_WIDTH-1:0] OUT_DC,
    output logic [CNT_WIDTH-1:0]    OUT_PERIOD,
    output logic                    OUT_VALID,
    output logic                    OUT_STUCK,
    output logic                    OUT_OVERRUN
);

    localparam logic [CNT_WIDTH-1:0] CntOne      = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CntMax      = '1;
    localparam logic [CNT_WIDTH-1:0] TimeoutLast = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic       sync1_q, sync2_q, dly_q;
    logic [1:0] warm_q;
    logic       rise_det, fall_det;

    pwm_state_e           state_q, state_d;
    logic [CNT_WIDTH-1:0] period_cnt_q, period_cnt_d;
    logic [CNT_WIDTH-1:0] high_cnt_q, high_cnt_d;
    logic [CNT_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
    logic                 meas_ok_q, meas_ok_d;
    logic [CNT_WIDTH-1:0] per_lat_q;
    logic                 stuck_pend_q, stuck_pend_d;
    logic                 stuck_lvl_q, stuck_lvl_d;

    logic [PWM_DC_WIDTH-1:0] out_dc_q;
    logic [CNT_WIDTH-1:0]    out_period_q;
    logic                    out_valid_q;
    logic                    out_overrun_q;

    logic                    timeout;
    logic                    enter_stuck;
    logic                    start;
    logic                    overrun;
    logic                    stuck_rep;
    logic                    div_busy, div_done;
    logic [PWM_DC_WIDTH-1:0] div_quo;

    // Edges are only trusted once the synchronizer and delay flop hold real samples,
    // so a level present at reset release is not mistaken for an edge.
    assign rise_det = (warm_q == 2'd3) && sync2_q && !dly_q;
    assign fall_det = (warm_q == 2'd3) && !sync2_q && dly_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            dly_q   <= 1'b0;
            warm_q  <= 2'd0;
        end else begin
            sync1_q <= IN_PWM;
            sync2_q <= sync1_q;
            dly_q   <= sync2_q;
            if (warm_q != 2'd3) begin
                warm_q <= warm_q + 2'd1;
            end
        end
    end

    assign timeout = (edge_cnt_q == TimeoutLast);

    always_comb begin
        state_d      = state_q;
        meas_ok_d    = meas_ok_q;
        start        = 1'b0;
        overrun      = 1'b0;
        enter_stuck  = 1'b0;

        if (rise_det) begin
            period_cnt_d = CntOne;
            high_cnt_d   = CntOne;
            edge_cnt_d   = '0;
        end else begin
            period_cnt_d = (period_cnt_q == CntMax) ? period_cnt_q : period_cnt_q + CntOne;
            high_cnt_d   = high_cnt_q;
            if (state_q == StHigh && !fall_det && high_cnt_q != CntMax) begin
                high_cnt_d = high_cnt_q + CntOne;
            end
            if (fall_det) begin
                edge_cnt_d = '0;
            end else begin
                edge_cnt_d = (edge_cnt_q == CntMax) ? edge_cnt_q : edge_cnt_q + CntOne;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (rise_det) begin
                    state_d   = StHigh;
                    meas_ok_d = 1'b1;
                end else if (timeout) begin
                    enter_stuck = 1'b1;
                end
            end
            StHigh: begin
                if (fall_det) begin
                    state_d = StLow;
                end else if (timeout) begin
                    enter_stuck = 1'b1;
                end
            end
            StLow: begin
                if (rise_det) begin
                    state_d   = StHigh;
                    meas_ok_d = 1'b1;
                    if (meas_ok_q) begin
                        overrun = div_busy;
                        start   = !div_busy;
                    end
                end else if (timeout) begin
                    enter_stuck = 1'b1;
                end
            end
            StStuck: begin
                if (rise_det) begin
                    state_d   = StHigh;
                    meas_ok_d = 1'b1;
                end else if (fall_det) begin
                    // Leaving through a fall gives no trustworthy period start.
                    state_d      = StLow;
                    meas_ok_d    = 1'b0;
                    period_cnt_d = '0;
                    high_cnt_d   = '0;
                    edge_cnt_d   = '0;
                end
            end
        endcase

        if (enter_stuck) begin
            state_d = StStuck;
        end
    end

    // A stuck report waits until any in-flight division result has been delivered.
    always_comb begin
        stuck_lvl_d  = enter_stuck ? sync2_q : stuck_lvl_q;
        stuck_pend_d = stuck_pend_q;
        stuck_rep    = 1'b0;
        if (enter_stuck || stuck_pend_q) begin
            if (div_busy) begin
                stuck_pend_d = 1'b1;
            end else begin
                stuck_pend_d = 1'b0;
                stuck_rep    = 1'b1;
            end
        end
    end

    pwm_div #(
        .W         (PWM_DC_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_div (
        .clk_i   (CLK),
        .rst_i   (RESET),
        .start_i (start),
        .num_i   (high_cnt_q),
        .den_i   (period_cnt_q),
        .busy_o  (div_busy),
        .done_o  (div_done),
        .quo_o   (div_quo)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q       <= StIdle;
            period_cnt_q  <= '0;
            high_cnt_q    <= '0;
            edge_cnt_q    <= '0;
            meas_ok_q     <= 1'b0;
            per_lat_q     <= '0;
            stuck_pend_q  <= 1'b0;
            stuck_lvl_q   <= 1'b0;
            out_dc_q      <= '0;
            out_period_q  <= '0;
            out_valid_q   <= 1'b0;
            out_overrun_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            period_cnt_q  <= period_cnt_d;
            high_cnt_q    <= high_cnt_d;
            edge_cnt_q    <= edge_cnt_d;
            meas_ok_q     <= meas_ok_d;
            stuck_pend_q  <= stuck_pend_d;
            stuck_lvl_q   <= stuck_lvl_d;
            out_overrun_q <= overrun;
            if (start) begin
                per_lat_q <= period_cnt_q;
            end
            if (div_done) begin
                out_dc_q     <= div_quo;
                out_period_q <= per_lat_q;
                out_valid_q  <= 1'b1;
            end else if (stuck_rep) begin
                out_dc_q     <= stuck_lvl_d ? '1 : '0;
                out_period_q <= '0;
                out_valid_q  <= 1'b1;
            end else begin
                out_valid_q  <= 1'b0;
            end
        end
    end

    assign OUT_DC      = out_dc_q;
    assign OUT_PERIOD  = out_period_q;
    assign OUT_VALID   = out_valid_q;
    assign OUT_STUCK   = (state_q == StStuck);
    assign OUT_OVERRUN = out_overrun_q;

endmodule
